// File: rtl/fetch_stage.sv
// fetch_stage: PC register, IF/ID pipeline register, redirect/stall/flush handling and sticky misaligned-target fault.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic [31:0] InstrIn,
  output logic [31:0] PCAddr,
  output logic [31:0] IF_ID_Instr,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid,
  output logic [31:0] FetchCount,
  output logic        Fault
);
  typedef enum logic {RUN, FAULT} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, pcp4_q, pcp4_d, count_q, count_d;
  logic valid_q, valid_d;
  logic [31:0] pc_plus4, target;
  logic redirect, bubble;
  assign pc_plus4 = pc_q + 32'd4;
  assign redirect = Jump | BranchTaken;
  assign target   = Jump ? JumpTarget : BranchTarget;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    count_d = count_q;
    bubble  = 1'b0;
    if (state_q == RUN) begin
      if (redirect) begin
        bubble  = 1'b1;
        state_d = (target[1:0] != 2'b00) ? FAULT : RUN;
        pc_d    = (target[1:0] != 2'b00) ? pc_q : target;
      end else if (Flush) begin
        bubble = 1'b1;
        pc_d   = pc_plus4;
      end else if (!Stall) begin
        pc_d    = pc_plus4;
        instr_d = InstrIn;
        pcp4_d  = pc_plus4;
        valid_d = 1'b1;
        count_d = count_q + 32'd1;
      end
    end
    if (bubble) begin
      instr_d = NOP_INSTR;
      pcp4_d  = 32'd0;
      valid_d = 1'b0;
    end
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pcp4_q  <= 32'd0;
      valid_q <= 1'b0;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end
  assign PCAddr        = pc_q;
  assign IF_ID_Instr   = instr_q;
  assign IF_ID_PCPlus4 = pcp4_q;
  assign IF_ID_Valid   = valid_q;
  assign FetchCount    = count_q;
  assign Fault         = (state_q == FAULT);
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined datapath: holds the program counter, drives the instruction-memory address, and loads the IF/ID pipeline register with the fetched instruction and PC+4. IF_ID_PCPlus4 is the A operand of the 32-bit branch-target adder in ID (B = sign-extended offset << 2). The block also applies branch/jump redirects, stalls, flushes, and a sticky misaligned-target fault.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on Reset
- NOP_INSTR, 32'h0000_0000, instruction word inserted into IF/ID on a bubble

Ports:
- Clk  in  1  single clock; all state updates on its rising edge
- Reset  in  1  synchronous, active-high
- Stall  in  1  hazard unit: hold PC and IF/ID
- Flush  in  1  squash IF/ID contents (bubble)
- BranchTaken  in  1  redirect to BranchTarget (resolved downstream)
- BranchTarget  in  32  output of the branch-target adder
- Jump  in  1  redirect to JumpTarget
- JumpTarget  in  32  jump address
- InstrIn  in  32  instruction memory read data (combinational read of PCAddr)
- PCAddr  out  32  current PC, to instruction memory
- IF_ID_Instr  out  32  registered instruction
- IF_ID_PCPlus4  out  32  registered PC+4 of that instruction
- IF_ID_Valid  out  1  1 = IF/ID holds a real instruction
- FetchCount  out  32  instructions accepted into IF/ID since Reset
- Fault  out  1  sticky misaligned-redirect fault

## Operation
- State machine: RUN, FAULT. Reset -> RUN.
- RUN, per cycle, priority highest first:
  - Jump=1: if JumpTarget[1:0]!=0 -> FAULT; else PC <= JumpTarget; IF/ID <= bubble.
  - BranchTaken=1 (Jump=0): same as Jump using BranchTarget.
  - Flush=1 (no redirect): PC <= PC+4; IF/ID <= bubble.
  - Stall=1: PC and IF/ID hold; FetchCount holds.
  - Otherwise: PC <= PC+4; IF_ID_Instr <= InstrIn; IF_ID_PCPlus4 <= PC+4; IF_ID_Valid <= 1; FetchCount += 1.
- Redirect and Flush override Stall (redirect squashes wrong-path instruction even when stalled).
- Bubble: IF_ID_Instr <= NOP_INSTR, IF_ID_PCPlus4 <= 0, IF_ID_Valid <= 0; FetchCount not incremented.
- Entering FAULT: PC holds at its current value, IF/ID <= bubble, Fault <= 1.
- FAULT: PC, IF/ID, FetchCount frozen; all inputs except Reset ignored; exits only via Reset.
- Arithmetic: PC+4 is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000, no flag.
- FetchCount: 32-bit, wraps modulo 2^32.

## Timing
- Reset values: PCAddr=RESET_PC, IF_ID_Instr=NOP_INSTR, IF_ID_PCPlus4=0, IF_ID_Valid=0, FetchCount=0, Fault=0, state RUN.
- Reset takes effect on the edge where it is sampled high, regardless of state or other inputs; mid-redirect or mid-stall work is discarded.
- PCAddr is the PC register output directly (no combinational path from inputs).
- Fetch latency: instruction at PCAddr in cycle n appears on IF_ID_* after edge n (available in cycle n+1).
- Redirect latency: redirect sampled at edge n -> PCAddr = target in cycle n+1; first target instruction valid in IF/ID in cycle n+2.
- Fault asserts in the cycle following the offending edge and stays high until Reset.
- All outputs registered; no combinational input-to-output paths.

## Test plan
- Reset then 4 free-running cycles, InstrIn = 32'h1000_0001 + cycle index -> PCAddr 0,4,8,12,16; IF_ID_PCPlus4 4,8,12,16; IF_ID_Valid=1 from cycle 1; FetchCount=4.
- Stall high 2 cycles at PC=8 -> PCAddr stays 8, IF/ID and FetchCount unchanged; resumes at 12 after Stall drops.
- BranchTaken=1, BranchTarget=32'h0000_0040 with Stall=1 same cycle -> next PCAddr=0x40, IF_ID_Valid=0; next cycle IF_ID_PCPlus4=0x44. Jump and BranchTaken together with JumpTarget=0x80 -> PCAddr=0x80.
- Jump=1, JumpTarget=32'h0000_0042 -> Fault=1, PCAddr frozen, IF_ID_Valid=0; further redirects/fetches ignored; Reset -> Fault=0, PCAddr=RESET_PC.
- RESET_PC=32'hFFFF_FFF8, free run -> PCAddr FFFF_FFF8, FFFF_FFFC, 0000_0000; IF_ID_PCPlus4 wraps to 0 without Fault.
- Reset asserted during Flush+Stall -> all outputs at reset values next cycle.
